// File: rtl/smart_meter_pkg.sv
// Shared types and default constants for the smart-meter load/pump dispatcher.
package smart_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_HOLD
   } state_t;

   typedef enum logic [2:0] {
      DEC_NONE,
      DEC_ADD,
      DEC_PUMP_ON,
      DEC_PUMP_OFF,
      DEC_SHED
   } decision_t;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_N_LOADS   = 4;
   localparam int unsigned DEF_LOAD_STEP = 20;
   localparam int unsigned DEF_BATT_LOW  = 30;
   localparam int unsigned DEF_BATT_HIGH = 200;
   localparam int unsigned DEF_MIN_HOLD  = 4;

   // Index/counter width that stays legal (>=1 bit) for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/smart_meter_load_sel.sv
// Combinational priority search over the load enables: lowest-index off bit
// (next load to add) and highest-index on bit (next load to shed).
module smart_meter_load_sel
   import smart_meter_pkg::*;
#(
   parameter int unsigned N_LOADS = DEF_N_LOADS
) (
   input  logic [N_LOADS-1:0]             loads,
   output logic                           any_off,
   output logic [idx_width(N_LOADS)-1:0]  lowest_off,
   output logic                           any_on,
   output logic [idx_width(N_LOADS)-1:0]  highest_on
);

   localparam int unsigned IDX_W = idx_width(N_LOADS);

   always_comb begin
      any_off    = 1'b0;
      lowest_off = '0;
      any_on     = 1'b0;
      highest_on = '0;
      // Descending scan so the last hit is the lowest index.
      for (int unsigned i = N_LOADS; i > 0; i--) begin
         if (!loads[i-1]) begin
            any_off    = 1'b1;
            lowest_off = IDX_W'(i - 1);
         end
      end
      for (int unsigned i = 0; i < N_LOADS; i++) begin
         if (loads[i]) begin
            any_on     = 1'b1;
            highest_on = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/smart_meter_dispatch.sv
// Smart-meter dispatcher: registers surplus/deficit of each sample and, from
// IDLE, evaluates one sample at a time to add/shed loads or toggle the dump pump.
module smart_meter_dispatch
   import smart_meter_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned N_LOADS   = DEF_N_LOADS,
   parameter int unsigned LOAD_STEP = DEF_LOAD_STEP,
   parameter int unsigned BATT_LOW  = DEF_BATT_LOW,
   parameter int unsigned BATT_HIGH = DEF_BATT_HIGH,
   parameter int unsigned MIN_HOLD  = DEF_MIN_HOLD
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [DATA_W-1:0]   data_pos_in,
   input  logic [DATA_W-1:0]   data_neg_in,
   input  logic                data_valid_in,
   input  logic [DATA_W-1:0]   battery,
   output logic [DATA_W-1:0]   data_pos_out,
   output logic [DATA_W-1:0]   data_neg_out,
   output logic                data_valid_out,
   output logic [N_LOADS-1:0]  start_loads,
   output logic                start_pumps
);

   localparam int unsigned IDX_W  = idx_width(N_LOADS);
   localparam int unsigned HOLD_W = idx_width(MIN_HOLD);

   localparam logic [DATA_W-1:0] STEP_V = DATA_W'(LOAD_STEP);
   localparam logic [DATA_W-1:0] LOW_V  = DATA_W'(BATT_LOW);
   localparam logic [DATA_W-1:0] HIGH_V = DATA_W'(BATT_HIGH);

   state_t             state;
   state_t             state_next;
   decision_t          decision;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [HOLD_W-1:0]  hold_next;
   logic [N_LOADS-1:0] loads_next;
   logic               pump_next;

   logic [DATA_W-1:0]  pos_q;
   logic [DATA_W-1:0]  neg_q;
   logic [DATA_W-1:0]  batt_q;

   logic signed [DATA_W:0] diff_in;
   logic signed [DATA_W:0] mag_in;
   logic signed [DATA_W:0] diff_q;
   logic signed [DATA_W:0] mag_q;
   logic [DATA_W-1:0]      surplus_in;
   logic [DATA_W-1:0]      deficit_in;
   logic [DATA_W-1:0]      surplus;
   logic [DATA_W-1:0]      deficit;

   logic               any_off;
   logic               any_on;
   logic [IDX_W-1:0]   lowest_off;
   logic [IDX_W-1:0]   highest_on;
   logic [N_LOADS-1:0] add_mask;
   logic [N_LOADS-1:0] shed_mask;

   smart_meter_load_sel #(
      .N_LOADS (N_LOADS)
   ) u_load_sel (
      .loads      (start_loads),
      .any_off    (any_off),
      .lowest_off (lowest_off),
      .any_on     (any_on),
      .highest_on (highest_on)
   );

   // Sign bit of the widened difference selects which side is nonzero.
   always_comb begin
      diff_in    = $signed({1'b0, data_pos_in}) - $signed({1'b0, data_neg_in});
      mag_in     = -diff_in;
      surplus_in = diff_in[DATA_W] ? '0 : diff_in[DATA_W-1:0];
      deficit_in = diff_in[DATA_W] ? mag_in[DATA_W-1:0] : '0;

      diff_q  = $signed({1'b0, pos_q}) - $signed({1'b0, neg_q});
      mag_q   = -diff_q;
      surplus = diff_q[DATA_W] ? '0 : diff_q[DATA_W-1:0];
      deficit = diff_q[DATA_W] ? mag_q[DATA_W-1:0] : '0;
   end

   always_comb begin
      add_mask  = N_LOADS'(1) << lowest_off;
      shed_mask = N_LOADS'(1) << highest_on;
   end

   always_comb begin
      decision = DEC_NONE;
      if (surplus >= STEP_V && batt_q >= HIGH_V) begin
         if (any_off)
            decision = DEC_ADD;
         else if (!start_pumps)
            decision = DEC_PUMP_ON;
      end else if (deficit != '0) begin
         if (start_pumps)
            decision = DEC_PUMP_OFF;
         else if (batt_q <= LOW_V && any_on)
            decision = DEC_SHED;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      loads_next = start_loads;
      pump_next  = start_pumps;
      case (state)
         ST_IDLE: begin
            if (data_valid_in)
               state_next = ST_EVAL;
         end
         ST_EVAL: begin
            case (decision)
               DEC_ADD:      loads_next = start_loads | add_mask;
               DEC_PUMP_ON:  pump_next  = 1'b1;
               DEC_PUMP_OFF: pump_next  = 1'b0;
               DEC_SHED:     loads_next = start_loads & ~shed_mask;
               default:      ;
            endcase
            if (decision == DEC_NONE || MIN_HOLD == 0) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_HOLD;
               hold_next  = HOLD_W'(MIN_HOLD - 1);
            end
         end
         ST_HOLD: begin
            if (hold_cnt == '0)
               state_next = ST_IDLE;
            else
               hold_next = hold_cnt - 1'b1;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state          <= ST_IDLE;
         hold_cnt       <= '0;
         pos_q          <= '0;
         neg_q          <= '0;
         batt_q         <= '0;
         data_pos_out   <= '0;
         data_neg_out   <= '0;
         data_valid_out <= 1'b0;
         start_loads    <= '0;
         start_pumps    <= 1'b0;
      end else begin
         if (data_valid_in) begin
            pos_q        <= data_pos_in;
            neg_q        <= data_neg_in;
            batt_q       <= battery;
            data_pos_out <= surplus_in;
            data_neg_out <= deficit_in;
         end
         data_valid_out <= data_valid_in;
         state          <= state_next;
         hold_cnt       <= hold_next;
         start_loads    <= loads_next;
         start_pumps    <= pump_next;
      end
   end

endmodule
